// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Bridges the multicycle core's load/store port to one word-wide synchronous
//   SRAM bank. Each request is latched when it is accepted, then checked for
//   alignment and address range. A load extracts the addressed lane and
//   sign- or zero-extends it. A sub-word store does a read-modify-write of the
//   RAM word. The core waits until done pulses for one cycle.
//
//   Optional build macro MEM_ACCESS_UNIT_BYTE_ENABLE_EN:
//     adds ram_wr_be[3:0]. A sub-word store writes directly with byte enables:
//     the store lane is replicated across the word and there is no RAM read.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_addr          byte address
//   req_wr            1=store, 0=load
//   req_access        byte / half / word
//   req_unsigned      zero-extend loads when 1
//   req_wr_data       store data, lane in the low bits
//   rd_data           extended load result (0 for stores/exceptions), held
//   done              one-cycle completion pulse
//   exc_misaligned    misaligned access; qualifies done
//   exc_range         address outside the bank; qualifies done
//   ram_addr          RAM word address
//   ram_wr_ena        RAM write strobe
//   ram_wr_data       RAM write word
//   ram_wr_be         RAM byte enables (only with the macro defined)
//   ram_rd_data       RAM read data, one cycle after ram_addr
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package mem_access_pkg;
    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2
    } mem_access_t;
endpackage

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          DEPTH_WORDS = 1024,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    input  logic          req_wr,
    input  mem_access_t   req_access,
    input  logic          req_unsigned,
    input  logic [31:0]   req_wr_data,
    output logic [31:0]   rd_data,
    output logic          done,
    output logic          exc_misaligned,
    output logic          exc_range,
    output logic [AW-1:0] ram_addr,
    output logic          ram_wr_ena,
    output logic [31:0]   ram_wr_data,
`ifdef MEM_ACCESS_UNIT_BYTE_ENABLE_EN
    output logic [3:0]    ram_wr_be,
`endif
    input  logic [31:0]   ram_rd_data
);

`ifdef MEM_ACCESS_UNIT_BYTE_ENABLE_EN
    localparam bit DIRECT_SUBWORD_WRITE = 1'b1;
`else
    localparam bit DIRECT_SUBWORD_WRITE = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_RESP
    } state_t;

    state_t r_state, w_next;

    // Latched request
    logic [1:0]    r_lane;
    logic          r_wr;
    mem_access_t   r_access;
    logic          r_unsigned;
    logic [31:0]   r_wr_data;
    logic          r_exc_mis;
    logic          r_exc_rng;
    logic [AW-1:0] r_ram_addr;
    logic [31:0]   r_rd_data;

    // ------------------------------------------------------------------
    // Checks on the live request (used only on the accept cycle)
    // ------------------------------------------------------------------
    logic [31:0] w_offset;
    logic        w_is_byte, w_is_half, w_is_word;
    logic        w_mis, w_rng, w_exc;
    logic        w_accept;
    logic        w_unused;

    assign w_offset  = req_addr - BASE_ADDR;
    assign w_is_byte = (req_access == MEM_ACCESS_BYTE);
    assign w_is_half = (req_access == MEM_ACCESS_HALF);
    assign w_is_word = ~w_is_byte & ~w_is_half;
    // DEPTH_WORDS is a power of two, so "offset >= DEPTH_WORDS*4" is just
    // "any bit above the bank's byte-address width is set".
    assign w_rng     = |w_offset[31:AW+2];
    assign w_mis     = (w_is_half & req_addr[0]) | (w_is_word & (|req_addr[1:0]));
    assign w_exc     = w_mis | w_rng;
    assign w_accept  = req_valid & req_ready;
    assign w_unused  = ^w_offset[1:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // ------------------------------------------------------------------
    // FSM: next state and control outputs.
    // ram_wr_ena and done are masked by rst so that a reset arriving in the
    // write cycle drops the write in that very cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        ram_wr_ena = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_exc)
                        w_next = S_RESP;
                    else if (req_wr && (w_is_word || DIRECT_SUBWORD_WRITE))
                        w_next = S_WRITE;
                    else
                        w_next = S_READ;
                end
            end
            S_READ:    w_next = S_CAPTURE;
            S_CAPTURE: w_next = r_wr ? S_WRITE : S_RESP;
            S_WRITE: begin
                ram_wr_ena = ~rst;
                w_next     = S_RESP;
            end
            S_RESP: begin
                done   = ~rst;
                w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Load lane extraction from the RAM word arriving in S_CAPTURE
    // ------------------------------------------------------------------
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_load_val;

    always_comb begin
        case (r_lane)
            2'd0:    w_ld_byte = ram_rd_data[7:0];
            2'd1:    w_ld_byte = ram_rd_data[15:8];
            2'd2:    w_ld_byte = ram_rd_data[23:16];
            default: w_ld_byte = ram_rd_data[31:24];
        endcase
        w_ld_half = r_lane[1] ? ram_rd_data[31:16] : ram_rd_data[15:0];
        case (r_access)
            MEM_ACCESS_BYTE: w_load_val = {{24{~r_unsigned & w_ld_byte[7]}}, w_ld_byte};
            MEM_ACCESS_HALF: w_load_val = {{16{~r_unsigned & w_ld_half[15]}}, w_ld_half};
            default:         w_load_val = ram_rd_data;
        endcase
    end

    // ------------------------------------------------------------------
    // Store lane: the store data replicated across the word, plus the lane
    // mask. Both build variants derive the write word from these.
    // ------------------------------------------------------------------
    logic [31:0] w_lane_data;
    logic [3:0]  w_be;

    always_comb begin
        case (r_access)
            MEM_ACCESS_BYTE: begin
                w_lane_data = {4{r_wr_data[7:0]}};
                w_be        = 4'b0001 << r_lane;
            end
            MEM_ACCESS_HALF: begin
                w_lane_data = {2{r_wr_data[15:0]}};
                w_be        = r_lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_lane_data = r_wr_data;
                w_be        = 4'b1111;
            end
        endcase
    end

`ifdef MEM_ACCESS_UNIT_BYTE_ENABLE_EN
    always_comb begin
        ram_wr_data = 32'd0;
        ram_wr_be   = 4'd0;
        if (r_state == S_WRITE) ram_wr_data = w_lane_data;
        if (ram_wr_ena)         ram_wr_be   = w_be;
    end
`else
    // Word read back in S_CAPTURE for the read-modify-write merge
    logic [31:0] r_rdata;
    logic [31:0] w_merged;

    always_ff @(posedge clk) begin
        if (rst)                         r_rdata <= 32'd0;
        else if (r_state == S_CAPTURE)   r_rdata <= ram_rd_data;
    end

    always_comb begin
        for (int b = 0; b < 4; b++)
            w_merged[8*b +: 8] = w_be[b] ? w_lane_data[8*b +: 8] : r_rdata[8*b +: 8];
    end

    assign ram_wr_data = (r_state == S_WRITE) ? w_merged : 32'd0;
`endif

    // ------------------------------------------------------------------
    // Request latch and response data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane     <= 2'd0;
            r_wr       <= 1'b0;
            r_access   <= MEM_ACCESS_BYTE;
            r_unsigned <= 1'b0;
            r_wr_data  <= 32'd0;
            r_exc_mis  <= 1'b0;
            r_exc_rng  <= 1'b0;
            r_ram_addr <= '0;
            r_rd_data  <= 32'd0;
        end else begin
            if (w_accept) begin
                r_lane     <= req_addr[1:0];
                r_wr       <= req_wr;
                r_access   <= req_access;
                r_unsigned <= req_unsigned;
                r_wr_data  <= req_wr_data;
                r_exc_mis  <= w_mis;
                r_exc_rng  <= w_rng & ~w_mis;
                // Exceptions leave the RAM address untouched: no access.
                if (!w_exc)           r_ram_addr <= w_offset[AW+1:2];
                // Responses without load data report zero; loads overwrite
                // rd_data in S_CAPTURE, so it holds its value otherwise.
                if (w_exc || req_wr)  r_rd_data  <= 32'd0;
            end
            if (r_state == S_CAPTURE && !r_wr)
                r_rd_data <= w_load_val;
        end
    end

    assign ram_addr       = r_ram_addr;
    assign rd_data        = r_rd_data;
    assign exc_misaligned = done & r_exc_mis;
    assign exc_range      = done & r_exc_rng;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the multicycle core's memory port and one word-wide synchronous data SRAM bank.
- Accepts byte, half and word load/store requests and checks alignment and address range.
- Loads: extracts and sign- or zero-extends the addressed lane. Sub-word stores: read-modify-write against the word RAM.
- Core stalls on its ena input until done pulses.

Parameters:
BASE_ADDR, 32'h1000_0000, byte address of word 0 of the bank
DEPTH_WORDS, 1024, bank size in 32-bit words; power of two
AW, $clog2(DEPTH_WORDS), RAM word-address width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request strobe, sampled only when req_ready=1
req_ready  out  1  high in S_IDLE only
req_addr  in  32  byte address
req_wr  in  1  1=store, 0=load
req_access  in  mem_access_t  MEM_ACCESS_BYTE / MEM_ACCESS_HALF / MEM_ACCESS_WORD
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_wr_data  in  32  store data, lane in low bits
rd_data  out  32  extended load result, valid while done=1
done  out  1  one-cycle completion pulse
exc_misaligned  out  1  qualifies done
exc_range  out  1  qualifies done
ram_addr  out  AW  word address
ram_wr_ena  out  1  RAM write strobe
ram_wr_data  out  32  RAM write word
ram_rd_data  in  32  RAM read data, one cycle after ram_addr presented

Behaviour:
- Request latch: all req_* fields are latched on the accept cycle (req_valid & req_ready). Later input changes are ignored.
- Range check: offset = req_addr - BASE_ADDR (32-bit wraparound). Out of range when offset >= DEPTH_WORDS*4.
- Alignment check: half needs addr[0]=0; word needs addr[1:0]=0.
- Exception priority: misaligned over range. At most one exception bit is set per response.
- States:
  - S_IDLE: req_ready=1.
  - On accept with an exception: go to S_RESP.
  - On accept of a load or a sub-word store: go to S_READ.
  - On accept of a word store: go to S_WRITE.
  - S_READ: drive ram_addr = offset[AW+1:2]. Next state S_CAPTURE.
  - S_CAPTURE: register ram_rd_data. Next state: S_RESP for a load, S_WRITE for a sub-word store.
  - S_WRITE: drive ram_wr_ena=1 for exactly one cycle. ram_wr_data is the merged word:
    - byte: lane addr[1:0] replaced by req_wr_data[7:0];
    - half: lane addr[1] replaced by req_wr_data[15:0];
    - word: req_wr_data.
    Next state S_RESP.
  - S_RESP: done=1 for one cycle with exc_* valid. Next state S_IDLE.
- Load extraction: the selected lane is shifted to bit 0 and extended per req_unsigned. Word loads ignore req_unsigned.
- rd_data holds its value after done and is 0 for stores and exceptions.
- Latency, counted from accept cycle 0 to the done cycle:
  - exception: 1
  - word store: 2
  - load: 3
  - sub-word store: 4
- Exceptions never assert ram_wr_ena, and no RAM read is issued for them.
- req_valid while not ready is ignored; no queueing.
- Reset values: state S_IDLE, done=0, exc_*=0, rd_data=0, ram_wr_ena=0, ram_addr=0, ram_wr_data=0.
- Reset mid-operation: return to S_IDLE next cycle. A pending write is dropped, and no write occurs in the reset cycle or the cycle after it.
- rst has priority over req_valid in the same cycle.

Optional Feature:
MEM_ACCESS_UNIT_BYTE_ENABLE_EN
- Defined:
  - Adds output ram_wr_be [3:0].
  - Sub-word stores skip S_READ/S_CAPTURE and go straight to S_WRITE, so all stores have latency 2.
  - ram_wr_data carries the store lane replicated across the word: byte replicated 4x, half 2x.
  - ram_wr_be is 4'b1111 for word stores, one-hot lane for byte, 4'b0011 or 4'b1100 for half, and 0 when not writing.
- Undefined: no ram_wr_be port; read-modify-write path as specified above.

Test Plan:
- RAM word 0 = 32'h8899_AABB; load byte at BASE+1, signed -> done at cycle 3, rd_data=32'hFFFF_FFAA, no exceptions.
- Same word; load half at BASE+2, unsigned -> rd_data=32'h0000_8899.
- Store byte 32'h0000_0055 at BASE+3 into 32'h8899_AABB -> single ram_wr_ena pulse with ram_wr_data=32'h5599_AABB, done at cycle 4 (cycle 2 with _EN: ram_wr_be=4'b1000, ram_wr_data=32'h5555_5555).
- Load word at BASE+2 -> done at cycle 1, exc_misaligned=1, no RAM read; load word at BASE+DEPTH_WORDS*4 -> exc_range=1; misaligned and out-of-range together -> only exc_misaligned=1.
- Word store accepted, rst asserted in S_WRITE cycle -> ram_wr_ena=0 thereafter, req_ready=1 the cycle after reset, done never pulses.
- req_valid held high during a load -> exactly one done; second request accepted on the cycle after done.
